fu_fifo_bank: RTL and testbench
===============================

# fu_fifo_bank

Parametrised multi-channel buffer bank for the PE functional-unit cluster. It replaces the fixed pair of depth-16 FIFOs with NUM_CH independent channels. Each channel is runtime-configurable as a flow-controlled FIFO or as a programmable fixed-latency delay line, and reports full/empty/occupancy and sticky error status. It sits beside the CMAC/DMEM/logical/CORDIC units and aligns operand streams between them.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one complex component; each entry is 2*DATA_WIDTH bits
- NUM_CH, 4, number of independent channels (1..16)
- DEPTH, 16, entries per channel; power of two, ≥2
- CW (local), $clog2(DEPTH+1), occupancy/delay field width

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  synchronous, active-high reset (1 = reset)
- cfg_we  in  1  write channel config this cycle
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel selected by cfg_we
- cfg_mode  in  1  0 = FIFO, 1 = DELAY
- cfg_delay  in  CW  delay in cycles for DELAY mode, legal 1..DEPTH
- flush_i  in  NUM_CH  per-channel flush
- wr_en  in  NUM_CH  write strobe (FIFO) / valid tag (DELAY)
- rd_en  in  NUM_CH  read strobe (FIFO only; ignored in DELAY)
- data_i  in  [NUM_CH][2*DATA_WIDTH]  write data
- data_o  out  [NUM_CH][2*DATA_WIDTH]  registered read data
- valid_o  out  NUM_CH  data_o holds a new entry this cycle
- full_o, empty_o  out  NUM_CH  FIFO status (DELAY: full_o=0, empty_o=1)
- count_o  out  [NUM_CH][CW]  FIFO occupancy (DELAY: 0)
- ovf_o, udf_o  out  NUM_CH  sticky overflow / underflow

## Operation
- Reset values: data_o=0, valid_o=0, empty_o=1, full_o=0, count_o=0, ovf_o=udf_o=0. Every channel comes up in FIFO mode with delay=1.
- cfg_we: latches mode/delay into the selected channel and flushes it that cycle. Same-cycle data strobes on that channel are ignored. A cfg_delay of 0 is stored as 1; a value above DEPTH is stored as DEPTH.
- Flush clears pointers, count, valid_o and the sticky flags. It does not clear data_o or the config. Flush wins over simultaneous rd/wr.
- FIFO mode, per channel:
  - Write is accepted if !full, or if full and a read is accepted in the same cycle.
  - A write at full with no read is dropped and sets ovf_o.
  - Read is accepted if !empty. It loads data_o with the oldest entry and sets valid_o=1 for the next cycle.
  - A read at empty sets udf_o. No fall-through: a write and a read on an empty channel in the same cycle gives a rejected read and an accepted write.
  - count' = count + wr_acc − rd_acc. full = (count==DEPTH), empty = (count==0).
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - data_o holds its last value when no read is accepted.
- DELAY mode, delay D:
  - Each cycle the pair {wr_en, data_i} is written at wptr and wptr increments.
  - The output reads slot wptr−D (mod DEPTH), so data_o/valid_o at cycle t+D equal data_i/wr_en sampled at t.
  - Storage contents are undefined after a flush, so valid_o is forced 0 for the first D cycles after the flush/config.
  - rd_en is ignored. ovf_o and udf_o never set.
- Channels are fully independent. Configuring one channel does not disturb any other.

## Timing
- FIFO read latency: rd_en at edge t gives data_o/valid_o at edge t+1.
- FIFO write-to-readable: a write at t makes empty_o drop after t+1, so the earliest accepted read is at t+1.
- DELAY latency: exactly D cycles, D in 1..DEPTH, with throughput 1 per cycle.
- Status outputs are registered and reflect state after the edge. They are not combinational from the strobes.
- Reset asserted mid-operation returns every channel to reset values at the next edge, regardless of other inputs.
- ovf_o/udf_o assert in the cycle after the offending edge and hold until flush, cfg_we on the channel, or reset.

## Structure
- Package fu_pkg: typedef cplx_t (logic [2*DATA_WIDTH-1:0]), enum ch_mode_e {CH_FIFO=1'b0, CH_DELAY=1'b1}, and function clamp_delay.
- Sub-module fu_fifo_ch holds one channel: storage (array of DEPTH × (2*DATA_WIDTH+1)), pointers, count, mode register and flags.
- fu_fifo_bank is a generate loop over NUM_CH plus cfg_ch decode.

## Test plan
- Reset, then 16 writes of 0x0001..0x0010 to ch0 with DEPTH=16 → full_o[0]=1, count=16. A 17th write alone is dropped and ovf_o[0]=1. Reading 16 times returns 0x0001..0x0010 in order, each one cycle after its rd_en, then empty_o[0]=1.
- Channel full with wr_en and rd_en together → count stays 16, read returns the oldest entry, the new word is stored, ovf_o stays 0. Empty channel with both strobes → udf_o=1, count=1, valid_o=0.
- cfg ch2 to DELAY with D=5, drive wr_en=1 and data=cycle index for 40 cycles → data_o[2] equals the index minus 5 with valid_o=1 from cycle 5 on, and valid_o=0 for cycles 0..4.
- DELAY with D=1 and D=16 (boundaries), plus cfg_delay=0 → the cfg_delay=0 case behaves as D=1. A gap pattern on wr_en is reproduced on valid_o exactly D cycles later.
- Pointer wrap: 100 interleaved write/read pairs on ch1 with random occupancy below DEPTH → data matches the scoreboard and the count never goes past 16.
- Mid-stream flush_i[0], cfg_we on ch3 and rst_n=1 pulse while other channels stream → only the targeted channel(s) reset, flags clear, and untouched channels lose no data.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared types and helpers for the functional-unit FIFO/delay bank.
// FU_DATA_WIDTH is the nominal component width used for cplx_t.
package fu_pkg;

  localparam int FU_DATA_WIDTH = 16;

  typedef logic [2*FU_DATA_WIDTH-1:0] cplx_t;

  typedef enum logic {
    CH_FIFO  = 1'b0,
    CH_DELAY = 1'b1
  } ch_mode_e;

  // Delay lines are only meaningful for 1..depth; out-of-range requests saturate.
  function automatic int clamp_delay(input int d, input int depth);
    if (d < 1) return 1;
    if (d > depth) return depth;
    return d;
  endfunction

endpackage

// File: rtl/fu_fifo_ch.sv
// One buffer channel: flow-controlled FIFO or fixed-latency delay line.
// Storage words carry a valid tag so the delay line can reproduce wr_en gaps.
module fu_fifo_ch
  import fu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int PW        = $clog2(DEPTH),
  localparam int EW        = 2 * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic          cfg_mode,
  input  logic [CW-1:0] cfg_delay,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [EW-1:0] data_i,
  output logic [EW-1:0] data_o,
  output logic          valid_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          ovf_o,
  output logic          udf_o
);

  logic [EW:0]   mem [DEPTH];
  logic [PW-1:0] wptr, rptr, rd_addr;
  logic [CW-1:0] count, delay, warm, delay_new;
  ch_mode_e      mode;
  logic          clr, is_fifo, rd_acc, wr_acc, mem_we;

  assign clr       = flush | cfg_we;
  assign is_fifo   = (mode == CH_FIFO);
  assign delay_new = CW'(clamp_delay(int'(cfg_delay), DEPTH));
  assign rd_acc    = is_fifo && !clr && rd_en && (count != '0);
  assign wr_acc    = is_fifo && !clr && wr_en && ((count != CW'(DEPTH)) || rd_acc);
  assign mem_we    = !clr && (wr_acc || !is_fifo);
  // For delay == DEPTH the low bits are zero, so the slot about to be overwritten is read.
  assign rd_addr   = is_fifo ? rptr : wptr - delay[PW-1:0];

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr] <= {wr_en, data_i};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      mode    <= CH_FIFO;
      delay   <= CW'(1);
      warm    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
      udf_o   <= 1'b0;
    end else if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
      udf_o   <= 1'b0;
      if (cfg_we) begin
        mode  <= ch_mode_e'(cfg_mode);
        delay <= delay_new;
        warm  <= delay_new;
      end else begin
        warm  <= delay;
      end
    end else if (is_fifo) begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr   <= rptr + 1'b1;
        data_o <= mem[rd_addr][EW-1:0];
      end
      valid_o <= rd_acc;
      count   <= count + CW'(wr_acc) - CW'(rd_acc);
      if (wr_en && !wr_acc) ovf_o <= 1'b1;
      if (rd_en && !rd_acc) udf_o <= 1'b1;
    end else begin
      wptr <= wptr + 1'b1;
      // Slots read during the first D cycles predate the flush and are stale.
      if (warm != '0) begin
        warm    <= warm - 1'b1;
        valid_o <= 1'b0;
      end else begin
        data_o  <= mem[rd_addr][EW-1:0];
        valid_o <= mem[rd_addr][EW];
      end
    end
  end

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

endmodule

// File: rtl/fu_fifo_bank.sv
// Bank of NUM_CH independent FIFO/delay-line channels with a shared config port.
module fu_fifo_bank
  import fu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_we,
  input  logic [CHW-1:0]                       cfg_ch,
  input  logic                                 cfg_mode,
  input  logic [CW-1:0]                        cfg_delay,
  input  logic [NUM_CH-1:0]                    flush_i,
  input  logic [NUM_CH-1:0]                    wr_en,
  input  logic [NUM_CH-1:0]                    rd_en,
  input  logic [NUM_CH-1:0][2*DATA_WIDTH-1:0]  data_i,
  output logic [NUM_CH-1:0][2*DATA_WIDTH-1:0]  data_o,
  output logic [NUM_CH-1:0]                    valid_o,
  output logic [NUM_CH-1:0]                    full_o,
  output logic [NUM_CH-1:0]                    empty_o,
  output logic [NUM_CH-1:0][CW-1:0]            count_o,
  output logic [NUM_CH-1:0]                    ovf_o,
  output logic [NUM_CH-1:0]                    udf_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_hit;
    assign cfg_hit = cfg_we && (cfg_ch == CHW'(i));

    fu_fifo_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_hit),
      .cfg_mode  (cfg_mode),
      .cfg_delay (cfg_delay),
      .flush     (flush_i[i]),
      .wr_en     (wr_en[i]),
      .rd_en     (rd_en[i]),
      .data_i    (data_i[i]),
      .data_o    (data_o[i]),
      .valid_o   (valid_o[i]),
      .full_o    (full_o[i]),
      .empty_o   (empty_o[i]),
      .count_o   (count_o[i]),
      .ovf_o     (ovf_o[i]),
      .udf_o     (udf_o[i])
    );
  end

endmodule

// File: tb/tb_fu_fifo_bank.sv
// Scoreboard bench for fu_fifo_bank: a behavioural model predicts every channel
// each cycle; expected outputs are queued with their due cycle and popped on compare.
module tb_fu_fifo_bank;
  import fu_pkg::*;

  localparam int NCH = 4;
  localparam int DEP = 16;
  localparam int CW  = $clog2(DEP + 1);

  typedef struct {
    int    due;
    logic  v;
    cplx_t data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [1:0]               cfg_ch = '0;
  logic                     cfg_mode = 1'b0;
  logic [CW-1:0]            cfg_delay = '0;
  logic [NCH-1:0]           flush_i = '0;
  logic [NCH-1:0]           wr_en = '0;
  logic [NCH-1:0]           rd_en = '0;
  logic [NCH-1:0][31:0]     data_i = '0;
  logic [NCH-1:0][31:0]     data_o;
  logic [NCH-1:0]           valid_o, full_o, empty_o, ovf_o, udf_o;
  logic [NCH-1:0][CW-1:0]   count_o;

  fu_fifo_bank #(.DATA_WIDTH(16), .NUM_CH(NCH), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .flush_i(flush_i),
    .wr_en(wr_en), .rd_en(rd_en), .data_i(data_i), .data_o(data_o),
    .valid_o(valid_o), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  exp_t  exp_q [NCH][$];
  cplx_t mq [NCH][$];
  int    mode_m [NCH];
  int    delay_m [NCH];
  bit    ovf_m [NCH];
  bit    udf_m [NCH];
  cplx_t last_data [NCH];
  bit    known [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int dclamp(input int d);
    if (d == 0) return 1;
    if (d > DEP) return DEP;
    return d;
  endfunction

  task automatic model(input int nx);
    exp_t e;
    bit   ra, wa, hit;
    for (int c = 0; c < NCH; c++) begin
      if (rst_n) begin
        mq[c].delete(); exp_q[c].delete();
        mode_m[c] = 0; delay_m[c] = 1; ovf_m[c] = 0; udf_m[c] = 0;
        last_data[c] = '0; known[c] = 1;
        continue;
      end
      hit = cfg_we && (int'(cfg_ch) == c);
      if (hit || flush_i[c]) begin
        mq[c].delete(); exp_q[c].delete(); ovf_m[c] = 0; udf_m[c] = 0;
        if (hit) begin
          mode_m[c]  = int'(cfg_mode);
          delay_m[c] = dclamp(int'(cfg_delay));
          if (cfg_mode) known[c] = 0;
        end
      end else if (mode_m[c] == 0) begin
        ra = rd_en[c] && (mq[c].size() > 0);
        wa = wr_en[c] && ((mq[c].size() < DEP) || ra);
        if (ra) begin
          e.due = nx; e.v = 1'b1; e.data = mq[c].pop_front();
          exp_q[c].push_back(e);
        end
        if (wa) mq[c].push_back(data_i[c]);
        if (wr_en[c] && !wa) ovf_m[c] = 1;
        if (rd_en[c] && !ra) udf_m[c] = 1;
      end else begin
        e.due = nx + delay_m[c]; e.v = wr_en[c]; e.data = data_i[c];
        exp_q[c].push_back(e);
      end
    end
  endtask

  task automatic check_all();
    exp_t e;
    int   cnt;
    for (int c = 0; c < NCH; c++) begin
      if (exp_q[c].size() > 0 && exp_q[c][0].due == cyc) begin
        e = exp_q[c].pop_front();
        check($sformatf("c%0d valid", c), 64'(valid_o[c]), 64'(e.v));
        check($sformatf("c%0d data", c), 64'(data_o[c]), 64'(e.data));
        last_data[c] = e.data; known[c] = 1;
      end else begin
        check($sformatf("c%0d idle valid", c), 64'(valid_o[c]), 64'(0));
        if (known[c]) check($sformatf("c%0d data hold", c), 64'(data_o[c]), 64'(last_data[c]));
      end
      cnt = (mode_m[c] == 0) ? mq[c].size() : 0;
      check($sformatf("c%0d count", c), 64'(count_o[c]), 64'(cnt));
      check($sformatf("c%0d full", c), 64'(full_o[c]), 64'(cnt == DEP));
      check($sformatf("c%0d empty", c), 64'(empty_o[c]), 64'(cnt == 0));
      check($sformatf("c%0d ovf", c), 64'(ovf_o[c]), 64'(ovf_m[c]));
      check($sformatf("c%0d udf", c), 64'(udf_o[c]), 64'(udf_m[c]));
    end
  endtask

  task automatic step();
    int nx;
    nx = cyc + 1;
    model(nx);
    @(posedge clk);
    cyc = nx;
    #1;
    check_all();
  endtask

  task automatic idle();
    cfg_we = 0; flush_i = '0; wr_en = '0; rd_en = '0; rst_n = 0;
  endtask

  task automatic cfg(input int ch, input bit m, input int d);
    idle();
    cfg_we = 1; cfg_ch = 2'(ch); cfg_mode = m; cfg_delay = CW'(d);
    step();
    cfg_we = 0;
  endtask

  task automatic run_delay(input int d, input int n, input bit gaps);
    cfg(2, 1'b1, d);
    for (int i = 0; i < n; i++) begin
      wr_en[2] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_en[2] = 1'($urandom_range(0, 1));
      data_i[2] = 32'(i);
      step();
    end
    idle();
  endtask

  initial begin
    rst_n = 1; step(); step();
    idle(); step();

    // fill ch0, overflow, drain in order
    for (int k = 1; k <= 16; k++) begin
      wr_en = 4'b0001; data_i[0] = 32'(k); step();
    end
    check("ch0 full after 16", 64'(full_o[0]), 64'(1));
    data_i[0] = 32'd17; step();
    check("ch0 ovf on 17th", 64'(ovf_o[0]), 64'(1));
    idle(); step();
    for (int k = 1; k <= 16; k++) begin
      rd_en = 4'b0001; step();
      check("ch0 read order", 64'(data_o[0]), 64'(k));
    end
    idle(); step();
    check("ch0 empty after drain", 64'(empty_o[0]), 64'(1));

    // simultaneous strobes at full and at empty
    flush_i = 4'b0001; step(); idle();
    for (int k = 1; k <= 16; k++) begin
      wr_en = 4'b0001; data_i[0] = 32'h1000 + 32'(k); step();
    end
    wr_en = 4'b0001; rd_en = 4'b0001; data_i[0] = 32'h100; step();
    check("full rw oldest", 64'(data_o[0]), 64'h1001);
    check("full rw count", 64'(count_o[0]), 64'(16));
    idle();
    for (int k = 0; k < 16; k++) begin rd_en = 4'b0001; step(); end
    idle(); step();
    wr_en = 4'b0001; rd_en = 4'b0001; data_i[0] = 32'h200; step();
    check("empty rw udf", 64'(udf_o[0]), 64'(1));
    check("empty rw count", 64'(count_o[0]), 64'(1));
    idle(); flush_i = 4'b0001; step(); idle();

    // delay-line modes on ch2, including clamped settings
    run_delay(5, 40, 1'b0);
    run_delay(1, 20, 1'b1);
    run_delay(16, 40, 1'b1);
    run_delay(0, 20, 1'b1);
    run_delay(20, 40, 1'b1);
    cfg(2, 1'b0, 1);

    // pointer wrap on ch1 with bounded random occupancy
    for (int i = 0; i < 100; i++) begin
      wr_en[1] = (mq[1].size() < DEP - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_en[1] = 1'($urandom_range(0, 1));
      data_i[1] = $urandom;
      step();
    end
    idle();
    for (int i = 0; i < DEP; i++) begin rd_en[1] = 1; step(); end
    idle();

    // targeted flush/config/reset while every channel streams
    cfg(2, 1'b1, 4);
    for (int i = 0; i < 60; i++) begin
      wr_en = 4'($urandom_range(0, 15));
      rd_en = 4'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) data_i[c] = $urandom;
      flush_i = (i == 20) ? 4'b0001 : 4'b0000;
      cfg_we = (i == 30); cfg_ch = 2'd3; cfg_mode = 1'b1; cfg_delay = CW'(2);
      rst_n = (i == 45);
      step();
    end
    idle();
    for (int i = 0; i < 20; i++) begin rd_en = 4'b1111; step(); end
    idle(); step();
    for (int c = 0; c < NCH; c++) check($sformatf("c%0d drained", c), 64'(exp_q[c].size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
